// File: rtl/mult_metrics_pkg.sv
// mult_metrics_pkg: shared types and constants for the multiplier error monitor.
//   state_t        - run-control FSM states (DIV only reachable with MULT_MRED_EN)
//   OPERAND_W      - width of each multiplier operand
//   PRODUCT_W      - width of the (exact or approximate) product
//   DEFAULT_FRAC_W - default fractional bits of the relative-error quotient
package mult_metrics_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DIV,
        DONE
    } state_t;

    localparam int unsigned OPERAND_W      = 4;
    localparam int unsigned PRODUCT_W      = 8;
    localparam int unsigned DEFAULT_FRAC_W = 16;

endpackage

// File: rtl/mult_error_monitor_if.sv
// mult_error_monitor_if: sample stream between the multiplier harness and the
// error monitor.
//   in_valid - sample tuple valid (master -> slave)
//   in_ready - monitor can accept a sample (slave -> master)
//   in_a     - multiplicand fed to the multiplier
//   in_b     - multiplier operand fed to the multiplier
//   in_p     - approximate product produced by the multiplier
interface mult_error_monitor_if;
    import mult_metrics_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [OPERAND_W-1:0] in_a;
    logic [OPERAND_W-1:0] in_b;
    logic [PRODUCT_W-1:0] in_p;

    modport master (output in_valid, in_a, in_b, in_p, input in_ready);
    modport slave  (input in_valid, in_a, in_b, in_p, output in_ready);

endinterface

// File: rtl/mult_error_monitor_seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per cycle.
//   clk, rst_n - clock, synchronous active-low reset
//   start      - load dividend/divisor and begin (restarts any division in flight)
//   dividend   - Q_W-bit dividend
//   divisor    - D_W-bit divisor (caller guarantees nonzero)
//   busy       - division in progress
//   valid      - high during the final iteration cycle; quotient is valid then
//   quotient   - Q_W-bit result (combinational, meaningful while valid)
// A division started at edge E0 runs Q_W iteration cycles and valid is high in
// the last one, so the consumer captures the result at edge E0+Q_W.
module seq_divider #(
    parameter int unsigned Q_W = 24,
    parameter int unsigned D_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [Q_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic           busy,
    output logic           valid,
    output logic [Q_W-1:0] quotient
);

    localparam int unsigned CNT_W = $clog2(Q_W);

    logic [CNT_W-1:0] cnt;
    logic [D_W-1:0]   rem;
    logic [D_W-1:0]   dvs;
    logic [Q_W-1:0]   dvd;
    logic [Q_W-1:0]   q;

    logic [D_W:0]     rem_sh;
    logic             ge;
    logic [D_W-1:0]   rem_nx;
    logic [Q_W-1:0]   q_nx;

    // Remainder always stays below the divisor, so D_W bits suffice after the
    // conditional subtract; the extra shifted-in bit only matters for compare.
    always_comb begin
        rem_sh   = {rem, dvd[Q_W-1]};
        ge       = (rem_sh >= {1'b0, dvs});
        rem_nx   = ge ? D_W'(rem_sh - {1'b0, dvs}) : rem_sh[D_W-1:0];
        q_nx     = {q[Q_W-2:0], ge};
        valid    = busy && (cnt == CNT_W'(Q_W - 1));
        quotient = q_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= 1'b0;
            cnt  <= '0;
            rem  <= '0;
            dvs  <= '0;
            dvd  <= '0;
            q    <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            rem  <= '0;
            dvs  <= divisor;
            dvd  <= dividend;
            q    <= '0;
        end else if (busy) begin
            rem <= rem_nx;
            dvd <= {dvd[Q_W-2:0], 1'b0};
            q   <= q_nx;
            cnt <= cnt + 1'b1;
            if (valid) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mult_error_monitor.sv
// mult_error_monitor: streaming error-metric stage behind multiplier_4x4.
// Recomputes the exact product of each accepted (a, b, p) tuple and accumulates
// error distance statistics over a run of N_SAMPLES samples.
//   clk, rst_n  - clock, synchronous active-low reset
//   start       - pulse: clear statistics and begin a run (beats a same-cycle accept)
//   s_if        - sample stream (in_valid/in_ready/in_a/in_b/in_p), slave side
//   done        - run complete, statistics stable until next start
//   sample_cnt  - samples accepted this run
//   err_cnt     - samples with nonzero error distance
//   max_ed      - largest error distance this run
//   sum_ed      - saturating sum of error distances
//   sum_red     - saturating sum of floor(ED*2^FRAC_W/exact); 0 without MULT_MRED_EN
// Build option: define MULT_MRED_EN to add the sequential relative-error divider.
module mult_error_monitor
    import mult_metrics_pkg::*;
#(
    parameter int unsigned N_SAMPLES = 256,
    parameter int unsigned ACC_W     = 32,
    parameter int unsigned FRAC_W    = DEFAULT_FRAC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    mult_error_monitor_if.slave s_if,
    output logic             done,
    output logic [15:0]      sample_cnt,
    output logic [15:0]      err_cnt,
    output logic [7:0]       max_ed,
    output logic [ACC_W-1:0] sum_ed,
    output logic [ACC_W-1:0] sum_red
);

    if (N_SAMPLES < 1 || N_SAMPLES > 65535 || ACC_W < PRODUCT_W || FRAC_W < 1) begin : g_bad_param
        $error("mult_error_monitor: parameter out of range");
    end

    localparam int unsigned ED_SUM_W = ((ACC_W > PRODUCT_W) ? ACC_W : PRODUCT_W) + 1;

    state_t state;
    state_t state_nx;

    logic                 accept;
    logic                 last;
    logic [PRODUCT_W-1:0] exact;
    logic [PRODUCT_W-1:0] ed;
    logic [ED_SUM_W-1:0]  ed_sum;
    logic [ACC_W-1:0]     sum_ed_nx;

    assign s_if.in_ready = (state == RUN);
    assign done          = (state == DONE);

    always_comb begin
        accept    = s_if.in_valid && s_if.in_ready && !start;
        exact     = PRODUCT_W'(s_if.in_a) * PRODUCT_W'(s_if.in_b);
        ed        = (s_if.in_p >= exact) ? (s_if.in_p - exact) : (exact - s_if.in_p);
        last      = (sample_cnt == 16'(N_SAMPLES - 1));
        ed_sum    = ED_SUM_W'(sum_ed) + ED_SUM_W'(ed);
        sum_ed_nx = (ed_sum > ED_SUM_W'({ACC_W{1'b1}})) ? '1 : ACC_W'(ed_sum);
    end

`ifdef MULT_MRED_EN
    localparam int unsigned Q_W      = PRODUCT_W + FRAC_W;
    localparam int unsigned RED_SUM_W = ((ACC_W > Q_W) ? ACC_W : Q_W) + 1;

    logic                 div_start;
    logic                 div_busy;
    logic                 div_valid;
    logic [Q_W-1:0]       div_quotient;
    logic [RED_SUM_W-1:0] red_sum;
    logic [ACC_W-1:0]     sum_red_nx;

    assign div_start = accept && (exact != '0);

    seq_divider #(
        .Q_W (Q_W),
        .D_W (PRODUCT_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend ({ed, FRAC_W'(0)}),
        .divisor  (exact),
        .busy     (div_busy),
        .valid    (div_valid),
        .quotient (div_quotient)
    );

    always_comb begin
        red_sum    = RED_SUM_W'(sum_red) + RED_SUM_W'(div_quotient);
        sum_red_nx = (red_sum > RED_SUM_W'({ACC_W{1'b1}})) ? '1 : ACC_W'(red_sum);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || start) begin
            sum_red <= '0;
        end else if (state == DIV && div_valid) begin
            sum_red <= sum_red_nx;
        end
    end
`else
    assign sum_red = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (start) begin
            state_nx = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (accept) begin
`ifdef MULT_MRED_EN
                        if (exact != '0) begin
                            state_nx = DIV;
                        end else if (last) begin
                            state_nx = DONE;
                        end
`else
                        if (last) begin
                            state_nx = DONE;
                        end
`endif
                    end
                end
`ifdef MULT_MRED_EN
                // Leaving on an idle divider keeps the FSM from ever hanging here.
                DIV: begin
                    if (div_valid || !div_busy) begin
                        state_nx = (sample_cnt == 16'(N_SAMPLES)) ? DONE : RUN;
                    end
                end
`endif
                default: state_nx = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || start) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            max_ed     <= '0;
            sum_ed     <= '0;
        end else if (accept) begin
            sample_cnt <= sample_cnt + 16'd1;
            if (ed != '0) begin
                err_cnt <= err_cnt + 16'd1;
            end
            if (ed > max_ed) begin
                max_ed <= ed;
            end
            sum_ed <= sum_ed_nx;
        end
    end

endmodule

// File: tb/tb_mult_error_monitor.sv
// tb_mult_error_monitor: directed bench for mult_error_monitor. Two instances
// (ACC_W=32 and ACC_W=8, both N_SAMPLES=4) see identical stimulus; a
// transaction-level model predicts every output each cycle, and literal
// expectations pin the key results. Follows MULT_MRED_EN if defined.
module tb_mult_error_monitor;

`ifdef MULT_MRED_EN
    localparam bit MRED = 1'b1;
`else
    localparam bit MRED = 1'b0;
`endif
    localparam int N      = 4;
    localparam int FRAC_W = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    always #5 clk = ~clk;

    mult_error_monitor_if if0 ();
    mult_error_monitor_if if1 ();

    logic        done0, done1;
    logic [15:0] cnt0, cnt1, err0, err1;
    logic [7:0]  max0, max1;
    logic [31:0] sed0, sred0;
    logic [7:0]  sed1, sred1;

    mult_error_monitor #(.N_SAMPLES(N), .ACC_W(32), .FRAC_W(FRAC_W)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .s_if(if0), .done(done0),
        .sample_cnt(cnt0), .err_cnt(err0), .max_ed(max0), .sum_ed(sed0), .sum_red(sred0));

    mult_error_monitor #(.N_SAMPLES(N), .ACC_W(8), .FRAC_W(FRAC_W)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .s_if(if1), .done(done1),
        .sample_cnt(cnt1), .err_cnt(err1), .max_ed(max1), .sum_ed(sed1), .sum_red(sred1));

    int n_vec  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] sat(input longint v, input int w);
        longint lim;
        lim = (longint'(1) << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    // Behavioural model: statistics as plain integers, availability as a
    // cycle countdown while a relative-error division is outstanding.
    int     m_cnt, m_err, m_max, m_divleft;
    longint m_sumed, m_sumred, m_pend;
    bit     m_ready, m_done;

    always @(posedge clk) begin
        int exact, ed;
        if (!rst_n) begin
            m_cnt = 0; m_err = 0; m_max = 0; m_sumed = 0; m_sumred = 0;
            m_ready = 0; m_done = 0; m_divleft = 0;
        end else if (start) begin
            m_cnt = 0; m_err = 0; m_max = 0; m_sumed = 0; m_sumred = 0;
            m_ready = 1; m_done = 0; m_divleft = 0;
        end else if (m_divleft > 0) begin
            m_divleft--;
            if (m_divleft == 0) begin
                m_sumred += m_pend;
                m_done  = (m_cnt == N);
                m_ready = !m_done;
            end
        end else if (m_ready && if0.in_valid) begin
            exact = int'(if0.in_a) * int'(if0.in_b);
            ed    = int'(if0.in_p) - exact;
            if (ed < 0) ed = -ed;
            m_cnt++;
            if (ed != 0) m_err++;
            if (ed > m_max) m_max = ed;
            m_sumed += ed;
            if (MRED && exact != 0) begin
                m_pend    = (longint'(ed) << FRAC_W) / exact;
                m_divleft = FRAC_W + 8;
                m_ready   = 0;
            end else if (m_cnt == N) begin
                m_ready = 0;
                m_done  = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready0", if0.in_ready, m_ready);
            chk("ready1", if1.in_ready, m_ready);
            chk("done0", done0, m_done);
            chk("done1", done1, m_done);
            chk("sample_cnt0", cnt0, m_cnt);
            chk("sample_cnt1", cnt1, m_cnt);
            chk("err_cnt0", err0, m_err);
            chk("err_cnt1", err1, m_err);
            chk("max_ed0", max0, m_max);
            chk("max_ed1", max1, m_max);
            chk("sum_ed0", sed0, sat(m_sumed, 32));
            chk("sum_ed1", sed1, sat(m_sumed, 8));
            chk("sum_red0", sred0, sat(m_sumred, 32));
            chk("sum_red1", sred1, sat(m_sumred, 8));
        end
    end

    task automatic drive(input bit v, input int a, input int b, input int p);
        if0.in_valid = v; if0.in_a = 4'(a); if0.in_b = 4'(b); if0.in_p = 8'(p);
        if1.in_valid = v; if1.in_a = 4'(a); if1.in_b = 4'(b); if1.in_p = 8'(p);
    endtask

    // All tasks enter and leave 2 time units after a rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input int a, input int b, input int p);
        bit got;
        got = 1'b0;
        drive(1'b1, a, b, p);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (if0.in_ready) begin
                got = 1'b1;
                break;
            end
        end
        chk("send_accept", got, 1'b1);
        tick();
        drive(1'b0, 0, 0, 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done0) break;
        end
        chk("wait_done", done0, 1'b1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int low;
        rst_n = 1'b0;
        start = 1'b0;
        drive(1'b0, 0, 0, 0);
        tick();
        chk_en = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_ready", if0.in_ready, 1'b0);
        chk("rst_done", done0, 1'b0);
        chk("rst_cnt", cnt0, 16'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Start: ready, statistics zero.
        pulse_start();
        @(negedge clk);
        chk("start_ready", if0.in_ready, 1'b1);
        chk("start_sum_ed", sed0, 32'd0);
        tick();

        // Four-sample run with exact-zero sample included.
        send(3, 5, 15);
        send(15, 15, 200);
        send(0, 7, 2);
        send(4, 4, 16);
        wait_done();
        @(negedge clk);
        chk("run1_done", done0, 1'b1);
        chk("run1_cnt", cnt0, 16'd4);
        chk("run1_err", err0, 16'd2);
        chk("run1_max", max0, 8'd25);
        chk("run1_sum_ed", sed0, 32'd27);
        chk("model_sum_ed", m_sumed, 64'd27);
        chk("model_sum_red", m_sumred, MRED ? 64'd7281 : 64'd0);
        tick();

        // in_valid held during DONE must be ignored.
        drive(1'b1, 1, 1, 0);
        repeat (4) tick();
        drive(1'b0, 0, 0, 0);
        @(negedge clk);
        chk("done_hold_cnt", cnt0, 16'd4);
        chk("done_hold_done", done0, 1'b1);
        tick();

        // Restart mid-run; start beats a simultaneous valid.
        pulse_start();
        send(1, 1, 0);
        send(2, 2, 0);
        drive(1'b1, 5, 5, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        drive(1'b0, 0, 0, 0);
        @(negedge clk);
        chk("restart_cnt", cnt0, 16'd0);
        chk("restart_sum_ed", sed0, 32'd0);
        chk("restart_max", max0, 8'd0);
        tick();
        send(1, 2, 3);
        send(2, 3, 6);
        send(3, 3, 8);
        @(negedge clk);
        chk("restart_not_done", done0, 1'b0);
        tick();
        send(7, 7, 50);
        wait_done();
        @(negedge clk);
        chk("run2_cnt", cnt0, 16'd4);
        chk("run2_err", err0, 16'd3);
        chk("run2_max", max0, 8'd1);
        chk("run2_sum_ed", sed0, 32'd3);
        tick();

        // Saturation of the narrow accumulator.
        pulse_start();
        repeat (4) send(15, 15, 0);
        wait_done();
        @(negedge clk);
        chk("sat_sum_ed8", sed1, 8'd255);
        chk("sat_sum_ed32", sed0, 32'd900);
        chk("sat_max", max1, 8'd225);
        tick();

        // Exact product zero: no division, relative error unchanged.
        pulse_start();
        send(0, 7, 2);
        tick();
        @(negedge clk);
        chk("zero_ready", if0.in_ready, 1'b1);
        chk("zero_sum_ed", sed0, 32'd2);
        chk("zero_sum_red", sred0, 32'd0);
        tick();

        // Single relative-error division: ED=1, exact=4.
        send(2, 2, 5);
        low = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (if0.in_ready) break;
            low++;
        end
        chk("div_len", low, MRED ? 24 : 0);
        chk("div_sum_red32", sred0, MRED ? 32'h4000 : 32'd0);
        chk("div_sum_red8", sred1, MRED ? 8'd255 : 8'd0);
        tick();

        // Reset during a division (mid-run without the divider).
        send(1, 1, 0);
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", if0.in_ready, 1'b0);
        chk("abort_cnt", cnt0, 16'd0);
        chk("abort_sum_ed", sed0, 32'd0);
        chk("abort_sum_red", sred0, 32'd0);
        tick();

        // Normal operation after the abort.
        pulse_start();
        send(3, 3, 10);
        repeat (30) tick();
        @(negedge clk);
        chk("post_cnt", cnt0, 16'd1);
        chk("post_sum_ed", sed0, 32'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
